// File: rtl/qpsk_frame_sync_if.sv
// Stream bundle for the QPSK frame synchroniser.
// Holds the IQ sample input and the byte output handshakes.
// The slave view belongs to the frame sync block and the master view to whatever drives it.
interface qpsk_frame_sync_if;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tlast,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tlast,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/qpsk_frame_sync.sv
// QPSK frame synchroniser.
// Sits after the Costas loop. It decimates to one sample per symbol and hard-slices each symbol.
// It searches for the sync word under all four quarter-turn rotations.
// Once locked it de-rotates the payload, packs it MSB-first into bytes and emits fixed-length frames.
module qpsk_frame_sync #(
  parameter int          SPS          = 4,
  parameter int          STROBE_PHASE = 0,
  parameter int          SYNC_BITS    = 32,
  parameter logic [63:0] SYNC_WORD    = 64'h1ACFFC1D,
  parameter int          MAX_ERR      = 2,
  parameter int          FRAME_BYTES  = 128
) (
  input  logic               ce_clk,
  input  logic               ce_rst_n,
  qpsk_frame_sync_if.slave   bus,
  output logic               locked,
  output logic [1:0]         rot,
  output logic [15:0]        frame_cnt
);

  localparam int HALF   = SYNC_BITS / 2;
  localparam int CNT_W  = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int FILL_W = $clog2(HALF + 1);
  localparam logic [SYNC_BITS-1:0] SYNC_PAT  = SYNC_WORD[SYNC_BITS-1:0];
  localparam logic [15:0]          LAST_BYTE = 16'(FRAME_BYTES - 1);

  typedef enum logic {SEARCH, PAYLOAD} state_t;

  // One quarter turn {a,b} -> {~b,a}, applied k times.
  function automatic logic [1:0] rot_sym(input logic [1:0] s, input logic [1:0] k);
    logic [1:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(k)) r = {~r[0], r[1]};
    end
    return r;
  endfunction

  // Symbol-wise rotation of a whole window.
  function automatic logic [SYNC_BITS-1:0] rot_word(input logic [SYNC_BITS-1:0] w,
                                                    input logic [1:0] k);
    logic [SYNC_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < HALF; i++) r[2*i +: 2] = rot_sym(w[2*i +: 2], k);
    return r;
  endfunction

  function automatic int popcnt(input logic [SYNC_BITS-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < SYNC_BITS; i++) c += int'(v[i]);
    return c;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     samp_cnt;
  logic [SYNC_BITS-1:0] window;
  logic [FILL_W-1:0]    fill;
  logic [1:0]           sym_cnt;
  logic [5:0]           byte_sh;
  logic [15:0]          byte_cnt;
  logic [1:0]           rot_q;
  logic                 locked_q;
  logic [15:0]          frame_cnt_q;

  logic signed [15:0]   samp_i_p0, samp_q_p0;
  logic [1:0]           sym_p0, sym_d_p0;
  logic [SYNC_BITS-1:0] win_next_p0;
  logic [7:0]           byte_next_p0;
  logic                 accept, strobe, fill_full_next;
  logic                 match, lock_evt, byte_evt, frame_evt;
  logic [1:0]           match_k;

  logic [7:0]           data_p1;
  logic                 last_p1;
  logic                 vld_p1;

  // ---- stage p0: accept, decimate, slice ----
  assign bus.s_axis_tready = !(vld_p1 && !bus.m_axis_tready);
  assign accept     = bus.s_axis_tvalid && bus.s_axis_tready;
  assign strobe     = accept && (samp_cnt == CNT_W'(STROBE_PHASE));
  assign samp_i_p0  = bus.s_axis_tdata[31:16];
  assign samp_q_p0  = bus.s_axis_tdata[15:0];
  assign sym_p0     = {samp_i_p0 < 16'sd0, samp_q_p0 < 16'sd0};
  assign sym_d_p0   = rot_sym(sym_p0, rot_q);
  assign byte_next_p0 = {byte_sh, sym_d_p0};
  assign win_next_p0  = (window << 2) | SYNC_BITS'(sym_p0);
  assign fill_full_next = (fill >= FILL_W'(HALF - 1));

  // Sync correlator: lowest rotation within the error budget wins.
  always_comb begin
    match   = 1'b0;
    match_k = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (popcnt(rot_word(win_next_p0, 2'(k)) ^ SYNC_PAT) <= MAX_ERR) begin
        match   = 1'b1;
        match_k = 2'(k);
      end
    end
  end

  // Next-state and event decode for the search/payload controller.
  always_comb begin
    state_d   = state_q;
    lock_evt  = 1'b0;
    byte_evt  = 1'b0;
    frame_evt = 1'b0;
    case (state_q)
      SEARCH: begin
        if (strobe && fill_full_next && match) begin
          state_d  = PAYLOAD;
          lock_evt = 1'b1;
        end
      end
      PAYLOAD: begin
        if (strobe && (sym_cnt == 2'd3)) begin
          byte_evt = 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            frame_evt = 1'b1;
            state_d   = SEARCH;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Controller state register.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) state_q <= SEARCH;
    else           state_q <= state_d;
  end

  // Sample phase counter, advancing on every accepted sample.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      samp_cnt <= '0;
    end else if (accept) begin
      if (samp_cnt == CNT_W'(SPS - 1)) samp_cnt <= '0;
      else                             samp_cnt <= samp_cnt + 1'b1;
    end
  end

  // Sync search window and fill level; emptied when a frame finishes.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      window <= '0;
      fill   <= '0;
    end else if (frame_evt) begin
      window <= '0;
      fill   <= '0;
    end else if ((state_q == SEARCH) && strobe) begin
      window <= win_next_p0;
      if (fill != FILL_W'(HALF)) fill <= fill + 1'b1;
    end
  end

  // Payload packer: symbol and byte counters plus partial byte.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      sym_cnt  <= '0;
      byte_sh  <= '0;
      byte_cnt <= '0;
    end else if (lock_evt) begin
      sym_cnt  <= '0;
      byte_sh  <= '0;
      byte_cnt <= '0;
    end else if ((state_q == PAYLOAD) && strobe) begin
      sym_cnt <= sym_cnt + 1'b1;
      byte_sh <= {byte_sh[3:0], sym_d_p0};
      if (byte_evt) byte_cnt <= frame_evt ? 16'd0 : byte_cnt + 16'd1;
    end
  end

  // ---- stage p1: one-deep output byte register ----
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (byte_evt) begin
      vld_p1  <= 1'b1;
      data_p1 <= byte_next_p0;
      last_p1 <= frame_evt;
    end else if (bus.m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Lock status, matched rotation and frame counter.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      locked_q    <= 1'b0;
      rot_q       <= 2'd0;
      frame_cnt_q <= '0;
    end else if (lock_evt) begin
      locked_q <= 1'b1;
      rot_q    <= match_k;
    end else if (frame_evt) begin
      locked_q    <= 1'b0;
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.m_axis_tdata  = data_p1;
  assign bus.m_axis_tlast  = last_p1;
  assign bus.m_axis_tvalid = vld_p1;
  assign locked            = locked_q;
  assign rot               = rot_q;
  assign frame_cnt         = frame_cnt_q;

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Directed bench for qpsk_frame_sync.
// It sends ideal QPSK symbols as four samples each and collects the output bytes on the negedge.
// A channel rotation of m quarter turns is undone by de-rotation index (4-m)%4.
module tb_qpsk_frame_sync;
  localparam int SPS = 4;
  localparam logic [31:0] SYNC = 32'h1ACFFC1D;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n = 1'b0;
  logic        locked;
  logic [1:0]  rot;
  logic [15:0] frame_cnt;
  logic        rdy = 1'b1;
  bit          rand_ready = 1'b0;

  always #5 ce_clk = ~ce_clk;

  qpsk_frame_sync_if bus();
  assign bus.m_axis_tready = rdy;

  qpsk_frame_sync #(
    .SPS(4), .STROBE_PHASE(0), .SYNC_BITS(32), .SYNC_WORD(64'h1ACFFC1D),
    .MAX_ERR(2), .FRAME_BYTES(128)
  ) dut (
    .ce_clk(ce_clk),
    .ce_rst_n(ce_rst_n),
    .bus(bus.slave),
    .locked(locked),
    .rot(rot),
    .frame_cnt(frame_cnt)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output sink readiness changes just after the active edge.
  always @(posedge ce_clk) begin
    #2;
    rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [7:0] rx_data[$];
  logic       rx_last[$];
  logic       prev_stall = 1'b0;
  logic [8:0] held = '0;
  int         stall_cnt = 0;

  // Output monitor: backpressure rule, hold-while-stalled, byte capture.
  always @(negedge ce_clk) begin
    if (!ce_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("s_tready", 32'(bus.s_axis_tready), 32'(!(bus.m_axis_tvalid && !bus.m_axis_tready)));
      if (prev_stall) chk("hold", 32'({bus.m_axis_tlast, bus.m_axis_tdata}), 32'(held));
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        rx_data.push_back(bus.m_axis_tdata);
        rx_last.push_back(bus.m_axis_tlast);
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      if (prev_stall) stall_cnt++;
      held = {bus.m_axis_tlast, bus.m_axis_tdata};
    end
  end

  task automatic send_sample(input logic signed [15:0] i, input logic signed [15:0] q);
    int n;
    bit acc;
    n = 0;
    bus.s_axis_tdata  = {i, q};
    bus.s_axis_tvalid = 1'b1;
    do begin
      @(negedge ce_clk);
      acc = bus.s_axis_tready;
      @(posedge ce_clk);
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  // Samples lo..hi of one symbol; alt inverts the non-strobe samples.
  task automatic send_sym(input logic [1:0] sym, input int m, input bit alt,
                          input int lo = 0, input int hi = SPS - 1);
    logic [1:0]         v;
    logic signed [15:0] i, q, t;
    for (int s = lo; s <= hi; s++) begin
      v = (alt && s != 0) ? ~sym : sym;
      i = v[1] ? -16'sd8000 : 16'sd8000;
      q = v[0] ? -16'sd8000 : 16'sd8000;
      for (int r = 0; r < m; r++) begin
        t = i;
        i = -q;
        q = t;
      end
      send_sample(i, q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int m, input bit alt);
    for (int s = 0; s < 4; s++) send_sym(b[7-2*s -: 2], m, alt);
  endtask

  task automatic send_sync(input logic [31:0] w, input int m, input bit alt);
    for (int s = 0; s < 16; s++) begin
      if (s == 15) chk("locked_before_sync_end", 32'(locked), 32'd0);
      send_sym(w[31-2*s -: 2], m, alt);
    end
  endtask

  task automatic drain(input int want);
    int n;
    n = 0;
    while (rx_data.size() < want && n < 3000) begin
      @(posedge ce_clk);
      n++;
    end
    repeat (4) @(posedge ce_clk);
    #1;
  endtask

  task automatic run_frame(input int m, input logic [31:0] errmask, input int npre,
                           input bit alt, input bit exp_lock, input logic [15:0] exp_fc,
                           input bit lat);
    int nbad, lastbad;
    logic [7:0] b;
    rx_data.delete();
    rx_last.delete();
    for (int k = 0; k < npre; k++) send_sym(2'($urandom_range(0, 3)), m, alt);
    send_sync(SYNC ^ errmask, m, alt);
    chk("locked", 32'(locked), 32'(exp_lock));
    if (!exp_lock) begin
      repeat (20) @(posedge ce_clk);
      #1;
      chk("no_bytes", 32'(rx_data.size()), 32'd0);
      chk("frame_cnt_nolock", 32'(frame_cnt), 32'(exp_fc));
      return;
    end
    chk("rot", 32'(rot), 32'((4 - m) % 4));
    for (int k = 0; k < 128; k++) begin
      b = 8'(k);
      if (k == 127) chk("locked_mid", 32'(locked), 32'd1);
      if (lat && k == 0) begin
        for (int s = 0; s < 3; s++) send_sym(b[7-2*s -: 2], m, alt);
        chk("tvalid_before", 32'(bus.m_axis_tvalid), 32'd0);
        send_sym(b[1:0], m, alt, 0, 0);
        chk("tvalid_latency", 32'(bus.m_axis_tvalid), 32'd1);
        chk("tdata_first", 32'(bus.m_axis_tdata), 32'h00);
        chk("tlast_first", 32'(bus.m_axis_tlast), 32'd0);
        send_sym(b[1:0], m, alt, 1, SPS - 1);
      end else begin
        send_byte(b, m, alt);
      end
    end
    drain(128);
    nbad = 0;
    lastbad = 0;
    foreach (rx_data[j]) begin
      if (rx_data[j] !== 8'(j)) nbad++;
      if (rx_last[j] !== (j == 127)) lastbad++;
    end
    chk("byte_count", 32'(rx_data.size()), 32'd128);
    chk("byte_values", 32'(nbad), 32'd0);
    chk("tlast_position", 32'(lastbad), 32'd0);
    chk("locked_after", 32'(locked), 32'd0);
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    ce_rst_n = 1'b0;
    repeat (3) @(posedge ce_clk);
    #1;
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
    chk("rst_s_tready", 32'(bus.s_axis_tready), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_rot", 32'(rot), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    @(posedge ce_clk);
    #1;

    // unrotated ideal frame with first-byte latency check
    run_frame(0, 32'h0, 0, 1'b0, 1'b1, 16'd1, 1'b1);
    // channel rotated by 90, 180, 270 degrees
    run_frame(1, 32'h0, 0, 1'b0, 1'b1, 16'd2, 1'b0);
    run_frame(2, 32'h0, 0, 1'b0, 1'b1, 16'd3, 1'b0);
    run_frame(3, 32'h0, 0, 1'b0, 1'b1, 16'd4, 1'b0);
    // error tolerance: 2 errors lock, 3 do not
    run_frame(0, 32'h0000_0003, 0, 1'b0, 1'b1, 16'd5, 1'b0);
    run_frame(0, 32'h8000_0003, 0, 1'b0, 1'b0, 16'd5, 1'b0);
    // random preamble, non-strobe samples carry opposite signs
    run_frame(0, 32'h0, 37, 1'b1, 1'b1, 16'd6, 1'b0);
    // random output backpressure
    rand_ready = 1'b1;
    stall_cnt  = 0;
    run_frame(0, 32'h0, 0, 1'b0, 1'b1, 16'd7, 1'b0);
    rand_ready = 1'b0;
    chk("stalls_seen", 32'(stall_cnt > 0), 32'd1);

    // reset while byte 50 is held in the output register
    rx_data.delete();
    rx_last.delete();
    @(posedge ce_clk);
    #1;
    send_sync(SYNC, 0, 1'b0);
    for (int k = 0; k < 50; k++) send_byte(8'(k), 0, 1'b0);
    for (int s = 0; s < 3; s++) send_sym(2'(50 >> (6 - 2*s)), 0, 1'b0);
    send_sym(2'(50), 0, 1'b0, 0, 0);
    chk("pre_reset_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("pre_reset_bytes", 32'(rx_data.size()), 32'd50);
    #2;
    ce_rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    @(posedge ce_clk);
    #1;
    run_frame(0, 32'h0, 0, 1'b0, 1'b1, 16'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
